// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: shared types, sizes and op-legality helpers for the stack sequencer.
//   op_t    - 3-bit request opcode (PUSH..NOT, RSVD)
//   state_t - sequencer FSM states
//   WIDTH/DEPTH/DW - data width, stack capacity, depth counter width
package stack_seq_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int DW    = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_TOS  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_AND  = 3'd5,
        OP_NOT  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef enum logic [2:0] {IDLE, POP1, WAIT1, POP2, WAIT2, PUSHR, RESP} state_t;

    function automatic logic is_binary(op_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND};
    endfunction

    // Overflow/underflow is decided from the tracked depth before any strobe,
    // since the stack itself has no full/empty flags.
    function automatic logic op_illegal(op_t op, logic [DW-1:0] depth);
        return op == OP_RSVD
            || (op == OP_PUSH && depth == DW'(DEPTH))
            || ((op == OP_POP || op == OP_TOS || op == OP_NOT) && depth == '0)
            || (is_binary(op) && depth < DW'(2));
    endfunction

endpackage

// File: rtl/stack_seq_if.sv
// stack_seq_if: request/response handshake, depth report and stack strobe bus.
//   req_valid/req_ready/req_op/req_data - operation request
//   rsp_valid/rsp_data/rsp_err/rsp_zero - one-cycle response pulse
//   depth                               - tracked number of stack entries
//   stk_din/stk_push/stk_pop/stk_tos    - strobes to the stack
//   stk_dout                            - registered stack read data
//   slave: sequencer side; master: requester + stack side
interface stack_seq_if;
    import stack_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             rsp_zero;
    logic [DW-1:0]    depth;
    logic [WIDTH-1:0] stk_din;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_tos;
    logic [WIDTH-1:0] stk_dout;

    modport slave (
        input  req_valid, req_op, req_data, stk_dout,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_zero, depth,
               stk_din, stk_push, stk_pop, stk_tos
    );

    modport master (
        output req_valid, req_op, req_data, stk_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_zero, depth,
               stk_din, stk_push, stk_pop, stk_tos
    );

endinterface

// File: rtl/stack_seq_alu.sv
// stack_seq_alu: combinational result of a stack op.
//   op_i     - latched opcode
//   a_i/b_i  - second-popped (a) and top (b) operands
//   imm_i    - latched PUSH operand
//   result_o - value to push back (modulo 2^WIDTH)
module stack_seq_alu
    import stack_seq_pkg::*;
(
    input  op_t              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb
        result_o = op_i == OP_ADD ? a_i + b_i :
                   op_i == OP_SUB ? a_i - b_i :
                   op_i == OP_AND ? a_i & b_i :
                   op_i == OP_NOT ? ~b_i : imm_i;

endmodule

// File: rtl/stack_seq.sv
// stack_seq: sequences push/pop/tos strobes for one stack-machine op per request.
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - stack_seq_if.slave: request/response handshake, depth, stack strobes
module stack_seq
    import stack_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    stack_seq_if.slave   bus
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d, result;
    logic             rsp_err_q, rsp_err_d, illegal;

    stack_seq_alu u_alu (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .imm_i   (imm_q),
        .result_o(result)
    );

    assign illegal = op_illegal(op_t'(bus.req_op), depth_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_PUSH;
            depth_q    <= '0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            depth_q    <= depth_d;
            imm_q      <= imm_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        depth_d    = depth_q;
        imm_d      = imm_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                op_d       = op_t'(bus.req_op);
                imm_d      = bus.req_data;
                rsp_err_d  = illegal;
                rsp_data_d = '0;
                state_d    = illegal ? RESP : op_t'(bus.req_op) == OP_PUSH ? PUSHR : POP1;
            end
            POP1: begin
                depth_d = op_q == OP_TOS ? depth_q : depth_q - DW'(1);
                state_d = WAIT1;
            end
            WAIT1: begin
                // POP/TOS report the read value; NOT/binary ops overwrite it in PUSHR.
                b_d        = bus.stk_dout;
                rsp_data_d = bus.stk_dout;
                state_d    = is_binary(op_q) ? POP2 : op_q == OP_NOT ? PUSHR : RESP;
            end
            POP2: begin
                depth_d = depth_q - DW'(1);
                state_d = WAIT2;
            end
            WAIT2: begin
                a_d     = bus.stk_dout;
                state_d = PUSHR;
            end
            PUSHR: begin
                depth_d    = depth_q + DW'(1);
                rsp_data_d = result;
                state_d    = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_zero  = state_q == RESP && !rsp_err_q && rsp_data_q == '0;
    assign bus.depth     = depth_q;
    assign bus.stk_push  = state_q == PUSHR;
    assign bus.stk_pop   = state_q == POP2 || (state_q == POP1 && op_q != OP_TOS);
    assign bus.stk_tos   = state_q == POP1 && op_q == OP_TOS;
    assign bus.stk_din   = state_q == PUSHR ? result : '0;

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: self-checking bench for stack_seq with a behavioural LIFO stack.
module tb_stack_seq;
    import stack_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_seq_if bus();

    stack_seq dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stack with registered read data, sharing the sequencer's reset.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [5:0]       sp;
    logic [4:0]       top_idx;
    assign top_idx = 5'(sp - 6'd1);

    always @(posedge clk) begin
        if (rst) begin
            sp           <= '0;
            bus.stk_dout <= '0;
        end else begin
            if (bus.stk_push && sp < 6'(DEPTH)) begin
                mem[sp[4:0]] <= bus.stk_din;
                sp           <= sp + 6'd1;
            end
            if (bus.stk_pop && sp != 0) begin
                bus.stk_dout <= mem[top_idx];
                sp           <= sp - 6'd1;
            end
            if (bus.stk_tos && sp != 0) bus.stk_dout <= mem[top_idx];
        end
    end

    int n_push, n_pop, n_tos, n_multi, n_rsp;
    logic [WIDTH-1:0] last_din;

    always @(posedge clk) begin
        if (!rst) begin
            n_push <= n_push + int'(bus.stk_push);
            n_pop  <= n_pop + int'(bus.stk_pop);
            n_tos  <= n_tos + int'(bus.stk_tos);
            n_rsp  <= n_rsp + int'(bus.rsp_valid);
            if (int'(bus.stk_push) + int'(bus.stk_pop) + int'(bus.stk_tos) > 1) n_multi <= n_multi + 1;
            if (bus.stk_push) last_din <= bus.stk_din;
        end
    end

    int n_chk, n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge with the sequencer idle; returns on a negedge with it idle again.
    task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] d,
                          input logic [7:0] e_data, input logic e_err, input int e_lat, input int e_depth);
        int p0, q0, t0, lat, e_pop;
        logic got, r_err, r_zero, e_push, e_tos;
        logic [7:0] r_data;
        p0 = n_push; q0 = n_pop; t0 = n_tos;
        r_data = '0; r_err = 1'b0; r_zero = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_data  = 8'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                got    = 1'b1;
                r_data = bus.rsp_data;
                r_err  = bus.rsp_err;
                r_zero = bus.rsp_zero;
            end
        end
        if (!got) lat = -1;
        chk({name, " latency"}, lat, e_lat);
        chk({name, " rsp_data"}, r_data, e_data);
        chk({name, " rsp_err"}, r_err, e_err);
        chk({name, " rsp_zero"}, r_zero, !e_err && e_data == 0);
        @(negedge clk);
        chk({name, " rsp one cycle"}, bus.rsp_valid, 0);
        chk({name, " ready"}, bus.req_ready, 1);
        chk({name, " depth"}, bus.depth, e_depth);
        e_push = !e_err && op != 1 && op != 2;
        e_tos  = !e_err && op == 2;
        e_pop  = e_err ? 0 : (op == 1 || op == 6) ? 1 : op inside {3, 4, 5} ? 2 : 0;
        chk({name, " push strobes"}, n_push - p0, e_push);
        chk({name, " pop strobes"}, n_pop - q0, e_pop);
        chk({name, " tos strobes"}, n_tos - t0, e_tos);
        if (e_push) chk({name, " stk_din"}, last_din, e_data);
    endtask

    // Reference: LIFO as a queue, rules applied directly to its contents.
    logic [7:0] q[$];

    task automatic model_run(input string name, input logic [2:0] op, input logic [7:0] d);
        int n, lat;
        logic err;
        logic [7:0] a, b, res;
        n   = q.size();
        err = op == 7 || (op == 0 && n == DEPTH) || (op inside {1, 2, 6} && n == 0)
              || (op inside {3, 4, 5} && n < 2);
        res = '0;
        lat = 1;
        if (!err) begin
            case (op)
                3'd0: begin q.push_back(d); res = d; lat = 2; end
                3'd1: begin res = q.pop_back(); lat = 3; end
                3'd2: begin res = q[n-1]; lat = 3; end
                3'd6: begin b = q.pop_back(); res = ~b; q.push_back(res); lat = 4; end
                default: begin
                    b = q.pop_back();
                    a = q.pop_back();
                    res = op == 3 ? 8'(a + b) : op == 4 ? 8'(a - b) : a & b;
                    q.push_back(res);
                    lat = 6;
                end
            endcase
        end
        run_op(name, op, d, res, err, lat, q.size());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] d;
        logic [7:0] data;
        logic       err;
        int         lat;
        int         depth;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [2:0] op, logic [7:0] d, logic [7:0] data, logic err, int lat, int depth);
        vec_t v;
        v = '{op, d, data, err, lat, depth};
        tbl.push_back(v);
    endfunction

    initial begin
        int p0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset rsp_data", bus.rsp_data, 0);
        chk("reset rsp_err", bus.rsp_err, 0);
        chk("reset rsp_zero", bus.rsp_zero, 0);
        chk("reset strobes", {bus.stk_push, bus.stk_pop, bus.stk_tos}, 0);
        chk("reset stk_din", bus.stk_din, 0);
        chk("reset depth", bus.depth, 0);
        chk("reset ready", bus.req_ready, 1);

        add(0, 8'h05, 8'h05, 0, 2, 1);
        add(1, 8'h00, 8'h05, 0, 3, 0);
        add(0, 8'h07, 8'h07, 0, 2, 1);
        add(0, 8'h03, 8'h03, 0, 2, 2);
        add(4, 8'h00, 8'h04, 0, 6, 1);
        add(2, 8'h00, 8'h04, 0, 3, 1);
        add(1, 8'h00, 8'h04, 0, 3, 0);
        add(0, 8'h03, 8'h03, 0, 2, 1);
        add(0, 8'h07, 8'h07, 0, 2, 2);
        add(4, 8'h00, 8'hFC, 0, 6, 1);
        add(1, 8'h00, 8'hFC, 0, 3, 0);
        add(0, 8'hFF, 8'hFF, 0, 2, 1);
        add(0, 8'h01, 8'h01, 0, 2, 2);
        add(3, 8'h00, 8'h00, 0, 6, 1);
        add(0, 8'h0F, 8'h0F, 0, 2, 2);
        add(5, 8'h00, 8'h00, 0, 6, 1);
        add(6, 8'h00, 8'hFF, 0, 4, 1);
        add(0, 8'h3C, 8'h3C, 0, 2, 2);
        add(5, 8'h00, 8'h3C, 0, 6, 1);
        add(1, 8'h00, 8'h3C, 0, 3, 0);
        add(1, 8'h00, 8'h00, 1, 1, 0);
        add(2, 8'h00, 8'h00, 1, 1, 0);
        add(6, 8'h00, 8'h00, 1, 1, 0);
        add(3, 8'h00, 8'h00, 1, 1, 0);
        add(0, 8'h11, 8'h11, 0, 2, 1);
        add(3, 8'h00, 8'h00, 1, 1, 1);
        add(4, 8'h00, 8'h00, 1, 1, 1);
        add(5, 8'h00, 8'h00, 1, 1, 1);
        add(7, 8'h55, 8'h00, 1, 1, 1);
        add(1, 8'h00, 8'h11, 0, 3, 0);
        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].d, tbl[i].data, tbl[i].err, tbl[i].lat, tbl[i].depth);

        do_reset();
        for (int i = 0; i < DEPTH; i++) model_run("fill", 0, 8'(i * 37 + 5));
        model_run("overflow", 0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) model_run("drain", 1, 8'h00);

        do_reset();
        model_run("pre-rst push", 0, 8'h21);
        model_run("pre-rst push", 0, 8'h42);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd3;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pop2 strobe", bus.stk_pop, 1);
        rst = 1'b1;
        p0 = n_rsp;
        @(negedge clk);
        chk("mid-op rst depth", bus.depth, 0);
        chk("mid-op rst ready", bus.req_ready, 1);
        rst = 1'b0;
        q.delete();
        begin
            int s0;
            s0 = n_push + n_pop + n_tos;
            repeat (8) @(negedge clk);
            chk("mid-op rst no rsp", n_rsp - p0, 0);
            chk("mid-op rst no strobes", n_push + n_pop + n_tos - s0, 0);
        end
        model_run("post-rst push", 0, 8'h5A);
        model_run("post-rst reserved", 7, 8'h00);

        do_reset();
        for (int k = 0; k < 400; k++) begin
            int bias, r;
            bias = ((k / 100) % 2 == 0) ? 12 : 0;
            r    = $urandom_range(0, 7 + bias);
            model_run("rand", r > 7 ? 3'd0 : 3'(r), 8'($urandom));
        end

        chk("strobes one-hot", n_multi, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
